// File: rtl/fp_pkg.sv
// Shared types and constant helpers for the sequential FP multiplier.
// Holds the FSM state enum, operand classes and IEEE constant builders.
package fp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_NORM,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    // Exponent bias for an exp_w-bit exponent field.
    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
    function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

    // Positive infinity; the caller places the sign bit.
    function automatic logic [63:0] inf_bits(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Normalize, round-to-nearest-even and range-check a raw significand product.
// Ports: i_prod (2*(MAN_W+1)-bit product), i_exp (signed unadjusted exponent),
//        i_sign; o_result (IEEE word), o_overflow, o_underflow, o_inexact.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [2*(MAN_W+1)-1:0]   i_prod,
    input  logic signed [EXP_W+1:0]  i_exp,
    input  logic                     i_sign,
    output logic [EXP_W+MAN_W:0]     o_result,
    output logic                     o_overflow,
    output logic                     o_underflow,
    output logic                     o_inexact
);

    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam int EW = EXP_W + 2;
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    logic                   w_msb;
    logic [PW-1:0]          w_norm;
    logic [SW-1:0]          w_mant;
    logic                   w_g;
    logic                   w_r;
    logic                   w_s;
    logic                   w_up;
    logic [SW:0]            w_sum;
    logic                   w_carry;
    logic [MAN_W-1:0]       w_frac;
    logic signed [EW-1:0]   w_exp;
    logic                   w_ovf;
    logic                   w_unf;

    // Product of two normalized significands lies in [1,4); bring it to [1,2).
    assign w_msb  = i_prod[PW-1];
    assign w_norm = w_msb ? i_prod : (i_prod << 1);
    assign w_mant = w_norm[PW-1 -: SW];
    assign w_g    = w_norm[SW-1];
    assign w_r    = w_norm[SW-2];
    assign w_s    = |w_norm[SW-3:0];

    // Round up above half, or at exactly half when the kept LSB is odd.
    assign w_up    = w_g & (w_r | w_s | w_mant[0]);
    assign w_sum   = {1'b0, w_mant} + (SW+1)'(w_up);
    assign w_carry = w_sum[SW];
    assign w_frac  = w_carry ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];

    assign w_exp = i_exp + EW'(w_msb) + EW'(w_carry);
    assign w_ovf = !w_exp[EW-1] && (w_exp >= EMAX);
    assign w_unf = w_exp[EW-1] || (w_exp == '0);

    always_comb begin
        o_result    = {i_sign, w_exp[EXP_W-1:0], w_frac};
        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        o_inexact   = w_g | w_r | w_s;
        if (w_ovf) begin
            o_result   = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            o_overflow = 1'b1;
            o_inexact  = 1'b1;
        end else if (w_unf) begin
            o_result    = {i_sign, {(W-1){1'b0}}};
            o_underflow = 1'b1;
            o_inexact   = |i_prod;
        end
    end

endmodule

// File: rtl/fp_multiplier_seq.sv
// Multi-cycle IEEE-754 multiplier with shift-add significand datapath.
// Ports: control/reset clock and sync reset; in_valid/in_ready with A, B;
//        out_valid/out_ready with out and overflow/underflow/invalid/inexact.
module fp_multiplier_seq
    import fp_pkg::*;
#(
    parameter int EXP_W          = 8,
    parameter int MAN_W          = 23,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                     control,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     A,
    input  logic [EXP_W+MAN_W:0]     B,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     invalid,
    output logic                     inexact
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SW   = MAN_W + 1;
    localparam int PW   = 2 * SW;
    localparam int EW   = EXP_W + 2;
    localparam int ITER = SW / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [W-1:0] QNAN  = W'(qnan_bits(EXP_W, MAN_W));
    localparam logic [W-1:0] INF_P = W'(inf_bits(EXP_W, MAN_W));
    localparam logic signed [EW-1:0] BIAS_V = EW'(bias_of(EXP_W));

    state_e               r_state;
    state_e               w_state_nxt;
    logic                 r_sign;
    logic signed [EW-1:0] r_exp;
    logic [PW-1:0]        r_acc;
    logic [PW-1:0]        r_mcand;
    logic [SW-1:0]        r_mplier;
    logic [CW-1:0]        r_cnt;
    logic [W-1:0]         r_out;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 r_inv;
    logic                 r_inx;

    logic [EXP_W-1:0]     w_ea;
    logic [EXP_W-1:0]     w_eb;
    logic [MAN_W-1:0]     w_fa;
    logic [MAN_W-1:0]     w_fb;
    logic                 w_sign;
    fp_class_e            w_cls_a;
    fp_class_e            w_cls_b;
    logic                 w_nan;
    logic                 w_inf;
    logic                 w_zero;
    logic                 w_special;
    logic [W-1:0]         w_spec_out;
    logic                 w_accept;
    logic                 w_last;
    logic [PW-1:0]        w_acc_nxt;

    logic [W-1:0]         w_rnd_out;
    logic                 w_rnd_ovf;
    logic                 w_rnd_unf;
    logic                 w_rnd_inx;

    assign w_ea   = A[W-2 -: EXP_W];
    assign w_eb   = B[W-2 -: EXP_W];
    assign w_fa   = A[MAN_W-1:0];
    assign w_fb   = B[MAN_W-1:0];
    assign w_sign = A[W-1] ^ B[W-1];

    // Denormal inputs (exp=0) are treated as zero.
    always_comb begin
        w_cls_a = CLS_NORM;
        w_cls_b = CLS_NORM;
        if (w_ea == '0)
            w_cls_a = CLS_ZERO;
        else if (w_ea == '1)
            w_cls_a = (w_fa == '0) ? CLS_INF : CLS_NAN;
        if (w_eb == '0)
            w_cls_b = CLS_ZERO;
        else if (w_eb == '1)
            w_cls_b = (w_fb == '0) ? CLS_INF : CLS_NAN;
    end

    assign w_nan = (w_cls_a == CLS_NAN) || (w_cls_b == CLS_NAN)
                || ((w_cls_a == CLS_INF) && (w_cls_b == CLS_ZERO))
                || ((w_cls_a == CLS_ZERO) && (w_cls_b == CLS_INF));
    assign w_inf  = (w_cls_a == CLS_INF) || (w_cls_b == CLS_INF);
    assign w_zero = (w_cls_a == CLS_ZERO) || (w_cls_b == CLS_ZERO);
    assign w_special = w_nan || w_inf || w_zero;

    always_comb begin
        w_spec_out = {w_sign, {(W-1){1'b0}}};
        if (w_nan)
            w_spec_out = QNAN;
        else if (w_inf)
            w_spec_out = {w_sign, INF_P[W-2:0]};
    end

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_cnt == CW'(ITER - 1));

    // Partial products for the next BITS_PER_CYCLE multiplier bits.
    always_comb begin
        w_acc_nxt = r_acc;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_mplier[j])
                w_acc_nxt = w_acc_nxt + (r_mcand << j);
        end
    end

    always_ff @(posedge control) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = w_special ? S_DONE : S_MUL;
            S_MUL:  if (w_last) w_state_nxt = S_NORM;
            S_NORM: w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge control) begin
        if (reset) begin
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inv    <= 1'b0;
            r_inx    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign   <= w_sign;
                r_exp    <= EW'(w_ea) + EW'(w_eb) - BIAS_V;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_mcand  <= PW'({1'b1, w_fa});
                r_mplier <= {1'b1, w_fb};
                if (w_special) begin
                    r_out <= w_spec_out;
                    r_ovf <= 1'b0;
                    r_unf <= 1'b0;
                    r_inv <= w_nan;
                    r_inx <= 1'b0;
                end
            end
            if (r_state == S_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << BITS_PER_CYCLE;
                r_mplier <= r_mplier >> BITS_PER_CYCLE;
                r_cnt    <= r_cnt + CW'(1);
            end
            if (r_state == S_NORM) begin
                r_out <= w_rnd_out;
                r_ovf <= w_rnd_ovf;
                r_unf <= w_rnd_unf;
                r_inv <= 1'b0;
                r_inx <= w_rnd_inx;
            end
        end
    end

    fp_round_rne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .i_prod      (r_acc),
        .i_exp       (r_exp),
        .i_sign      (r_sign),
        .o_result    (w_rnd_out),
        .o_overflow  (w_rnd_ovf),
        .o_underflow (w_rnd_unf),
        .o_inexact   (w_rnd_inx)
    );

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign invalid   = r_inv;
    assign inexact   = r_inx;

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Self-checking bench for fp_multiplier_seq at FP32 defaults.
// Directed plan cases, backpressure, mid-op reset and random operands.
module tb_fp_multiplier_seq;

    logic        control   = 1'b0;
    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] A         = '0;
    logic [31:0] B         = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        overflow;
    logic        underflow;
    logic        invalid;
    logic        inexact;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 control = ~control;

    fp_multiplier_seq dut (
        .control   (control),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid),
        .inexact   (inexact)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Returns {special, overflow, underflow, invalid, inexact, result}.
    function automatic logic [36:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
        logic s;
        logic [7:0] ea, eb;
        logic [22:0] fa, fb;
        logic nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
        longint unsigned ma, mb, p, kept, rem, half;
        int drop, e;
        s  = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        nan_a = (ea == 8'hFF) && (fa != 0);
        nan_b = (eb == 8'hFF) && (fb != 0);
        inf_a = (ea == 8'hFF) && (fa == 0);
        inf_b = (eb == 8'hFF) && (fb == 0);
        zer_a = (ea == 0);
        zer_b = (eb == 0);
        if (nan_a || nan_b || (inf_a && zer_b) || (inf_b && zer_a))
            return {1'b1, 4'b0010, 32'h7FC00000};
        if (inf_a || inf_b)
            return {1'b1, 4'b0000, s, 8'hFF, 23'h0};
        if (zer_a || zer_b)
            return {1'b1, 4'b0000, s, 31'h0};
        ma = 64'(fa) | (64'd1 << 23);
        mb = 64'(fb) | (64'd1 << 23);
        p  = ma * mb;
        drop = ((p >> 47) != 0) ? 24 : 23;
        kept = p >> drop;
        rem  = p & ((64'd1 << drop) - 1);
        half = 64'd1 << (drop - 1);
        if (rem > half || (rem == half && kept[0]))
            kept = kept + 1;
        if (kept == (64'd1 << 24)) begin
            kept = kept >> 1;
            drop = drop + 1;
        end
        e = int'(ea) + int'(eb) - 127 + drop - 23;
        if (e >= 255)
            return {1'b0, 4'b1001, s, 8'hFF, 23'h0};
        if (e <= 0)
            return {1'b0, 4'b0101, s, 31'h0};
        return {1'b0, 3'b000, (rem != 0), s, e[7:0], kept[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        int c;
        c = int'($urandom_range(0, 15));
        f = 23'($urandom);
        if (c == 0)      e = 8'h00;
        else if (c == 1) begin e = 8'hFF; f = 23'h0; end
        else if (c == 2) begin e = 8'hFF; f = f | 23'h1; end
        else if (c < 5)  e = 8'($urandom_range(200, 254));
        else if (c < 7)  e = 8'($urandom_range(1, 60));
        else             e = 8'($urandom_range(100, 154));
        return {1'($urandom), e, f};
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag,
                         output logic [31:0] got, output logic [3:0] gf);
        logic [36:0] m;
        int lat;
        int w;
        m = ref_mul(a, b);
        out_ready = (hold == 0);
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge control); #1;
            w++;
        end
        if (!in_ready) chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        A = a; B = b; in_valid = 1'b1;
        @(posedge control); #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge control); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), m[36] ? 64'd1 : 64'd26);
        got = out;
        gf  = {overflow, underflow, invalid, inexact};
        chk({tag, "_out"}, {gf, got}, 64'(m[35:0]));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge control); #1;
            chk({tag, "_hold"},
                {out_valid, in_ready, overflow, underflow, invalid, inexact, out},
                {2'b10, m[35:0]});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge control); #1;
        chk({tag, "_drain"},
            {out_valid, in_ready, overflow, underflow, invalid, inexact, out},
            {2'b01, m[35:0]});
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        int seen;

        reset = 1'b1;
        repeat (3) @(posedge control);
        #1;
        chk("rst_state",
            {out_valid, in_ready, overflow, underflow, invalid, inexact, out},
            {2'b01, 4'b0000, 32'h0});
        reset = 1'b0;
        @(posedge control); #1;
        chk("rst_rel_ready", 64'(in_ready), 64'd1);

        do_op(32'h40400000, 32'h40000000, 0, "mul3x2", r, f);
        chk("mul3x2_k", {f, r}, {4'b0000, 32'h40C00000});
        do_op(32'h3FC00000, 32'h3FC00000, 0, "sq1p5", r, f);
        chk("sq1p5_k", {f, r}, {4'b0000, 32'h40100000});
        do_op(32'h3F800001, 32'h3F800001, 0, "rne", r, f);
        chk("rne_k", {f, r}, {4'b0001, 32'h3F800002});
        do_op(32'h7F000000, 32'h7F000000, 0, "ovf", r, f);
        chk("ovf_k", {f, r}, {4'b1001, 32'h7F800000});
        do_op(32'h00800000, 32'h00800000, 0, "unf", r, f);
        chk("unf_k", {f, r}, {4'b0101, 32'h00000000});
        do_op(32'h7F800000, 32'h00000000, 0, "infx0", r, f);
        chk("infx0_k", {f, r}, {4'b0010, 32'h7FC00000});
        do_op(32'hFF800000, 32'h40000000, 0, "ninfx2", r, f);
        chk("ninfx2_k", {f, r}, {4'b0000, 32'hFF800000});
        do_op(32'h3F800001, 32'h3F800001, 5, "bp", r, f);
        chk("bp_k", {f, r}, {4'b0001, 32'h3F800002});

        out_ready = 1'b1;
        A = 32'h40400000; B = 32'h40000000; in_valid = 1'b1;
        @(posedge control); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge control);
        #1;
        reset = 1'b1;
        @(posedge control); #1;
        reset = 1'b0;
        chk("rst_mid", {out_valid, in_ready, out}, {2'b01, 32'h0});
        seen = 0;
        repeat (40) begin
            @(posedge control); #1;
            if (out_valid) seen++;
        end
        chk("rst_mid_nores", 64'(seen), 64'd0);

        for (int k = 0; k < 200; k++) begin
            int h;
            h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_op(rand_fp(), rand_fp(), h, "rnd", r, f);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
